// File: rtl/pseudo_linear_pkg.sv
// Shared constants, types and the saturating step used by every weight and the bias.
// The sum is wide enough for the bias plus all weights, so it can never overflow.
package pseudo_linear_pkg;

  localparam int N_IN     = 14;
  localparam int WEIGHT_W = 8;
  localparam int SUM_W    = WEIGHT_W + $clog2(N_IN + 2);

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef logic signed [SUM_W-1:0]    sum_t;

  localparam weight_t W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam weight_t W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

  // +1 at W_MAX and -1 at W_MIN are no-ops
  function automatic weight_t sat_step(input weight_t w, input logic up, input logic en);
    weight_t r;
    r = w;
    if (en) begin
      if (up) begin
        if (w != W_MAX) r = w + weight_t'(1);
      end else begin
        if (w != W_MIN) r = w - weight_t'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pl_weight_cell.sv
// One learned coefficient (a feature weight or the bias): a register that
// moves by a saturating +/-1 when enabled.
module pl_weight_cell
  import pseudo_linear_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_en,
  input  logic    i_up,
  output weight_t o_w
);

  weight_t r_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= '0;
    end else begin
      r_w <= sat_step(r_w, i_up, i_en);
    end
  end

  assign o_w = r_w;

endmodule

// File: rtl/pseudo_linear.sv
// Online perceptron over a 14-bit feature word: registered prediction one clock
// after x, trained by the label y arriving alongside that prediction.
module pseudo_linear
  import pseudo_linear_pkg::*;
#(
  parameter int unsigned TRAIN_LEN = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] x,
  input  logic            y,
  output logic            result
);

  logic [N_IN-1:0] r_x_q;
  logic            r_result;
  logic            r_valid;
  logic [31:0]     r_upd_cnt;

  weight_t         w_w [N_IN];
  weight_t         w_bias;
  sum_t            w_sum;
  logic            w_pred;
  logic            w_learn_en;
  logic            w_upd;
  logic            w_cnt_inc;

  // Sum of sign-extended bias and the weights of the active features
  always_comb begin
    w_sum = sum_t'(w_bias);
    for (int i = 0; i < N_IN; i++) begin
      if (x[i]) w_sum = w_sum + sum_t'(w_w[i]);
    end
  end

  assign w_pred     = ~w_sum[SUM_W-1];
  assign w_learn_en = (TRAIN_LEN == 0) || (r_upd_cnt < TRAIN_LEN);
  assign w_upd      = r_valid && w_learn_en && (r_result != y);

  // With TRAIN_LEN==0 the counter only serves as a sample count, so it just stops at all-ones
  assign w_cnt_inc  = r_valid && ((TRAIN_LEN == 0) ? (r_upd_cnt != '1) : (r_upd_cnt < TRAIN_LEN));

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_w
      pl_weight_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_upd & r_x_q[gi]),
        .i_up  (y),
        .o_w   (w_w[gi])
      );
    end
  endgenerate

  pl_weight_cell u_bias (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_upd),
    .i_up  (y),
    .o_w   (w_bias)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_q     <= '0;
      r_result  <= 1'b0;
      r_valid   <= 1'b0;
      r_upd_cnt <= '0;
    end else begin
      r_x_q    <= x;
      r_result <= w_pred;
      r_valid  <= 1'b1;
      if (w_cnt_inc) r_upd_cnt <= r_upd_cnt + 32'd1;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_pseudo_linear.sv
// Directed bench for pseudo_linear: three instances share stimulus, one learning
// forever, one freezing after 4 samples, one freezing after 2000 samples.
module tb_pseudo_linear;
  import pseudo_linear_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_IN-1:0] x;
  logic            y;
  logic            res0, res4, resl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pseudo_linear #(.TRAIN_LEN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .result(res0)
  );
  pseudo_linear #(.TRAIN_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .result(res4)
  );
  pseudo_linear #(.TRAIN_LEN(2000)) dutl (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .result(resl)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too
  task automatic step(input logic [N_IN-1:0] xv, input logic yv);
    x = xv;
    y = yv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic            seen_one;
    logic [N_IN-1:0] xs;
    logic            lab;
    int              n_ok;

    rst_n = 1'b0;
    x     = '1;
    y     = 1'b0;

    // Reset held with all features set
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_result", int'(res0), 0);
    end
    chk("rst_w0", int'(dut0.w_w[0]), 0);
    chk("rst_bias", int'(dut0.w_bias), 0);

    x     = '0;
    rst_n = 1'b1;
    step(14'h0000, 1'b0);
    chk("first_tie_result", int'(res0), 1);

    // Single mistake then confirm no update on correct predictions
    step(14'h0001, 1'b1);
    chk("e2_result", int'(res0), 1);
    chk("e2_w0", int'(dut0.w_w[0]), 0);
    step(14'h0000, 1'b0);
    chk("mistake_result_old_w", int'(res0), 1);
    chk("mistake_w0", int'(dut0.w_w[0]), -1);
    chk("mistake_bias", int'(dut0.w_bias), -1);
    step(14'h0001, 1'b1);
    chk("x1_sum_m2_result", int'(res0), 0);
    step(14'h0001, 1'b0);
    chk("correct_w0", int'(dut0.w_w[0]), -1);
    chk("correct_bias", int'(dut0.w_bias), -1);
    step(14'h0000, 1'b0);
    chk("x0_bias_only_result", int'(res0), 0);
    chk("correct2_w0", int'(dut0.w_w[0]), -1);
    chk("correct2_bias", int'(dut0.w_bias), -1);

    // Long run of x=2, y=1 from a negative bias
    seen_one = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(14'h0002, 1'b1);
      chk("sat_w1_le_max", int'(int'(dut0.w_w[1]) <= 127), 1);
      if (seen_one) chk("sat_result_sticky", int'(res0), 1);
      if (res0) seen_one = 1'b1;
    end
    chk("sat_final_w1", int'(dut0.w_w[1]), 1);
    chk("sat_final_bias", int'(dut0.w_bias), 1);
    chk("sat_final_w0", int'(dut0.w_w[0]), -1);

    // Saturating step at both rails and when disabled
    chk("step_up_at_max", int'(sat_step(W_MAX, 1'b1, 1'b1)), 127);
    chk("step_dn_at_min", int'(sat_step(W_MIN, 1'b0, 1'b1)), -128);
    chk("step_up_to_max", int'(sat_step(weight_t'(126), 1'b1, 1'b1)), 127);
    chk("step_dn_to_min", int'(sat_step(weight_t'(-127), 1'b0, 1'b1)), -128);
    chk("step_disabled", int'(sat_step(weight_t'(5), 1'b1, 1'b0)), 5);

    // Asynchronous reset mid-operation clears state without a clock edge
    rst_n = 1'b0;
    #2;
    chk("async_rst_w1", int'(dut0.w_w[1]), 0);
    chk("async_rst_bias", int'(dut0.w_bias), 0);
    chk("async_rst_result", int'(res0), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Four labelled samples, then x=1 with y=0 that would be mistakes if still learning
    step(14'h0002, 1'b0);
    chk("frz_e1_result", int'(res4), 1);
    step(14'h0001, 1'b0);
    step(14'h0001, 1'b1);
    chk("frz_e3_result", int'(res4), 0);
    step(14'h0004, 1'b1);
    chk("frz_e4_result", int'(res4), 0);
    step(14'h0001, 1'b1);
    chk("frz_e5_result", int'(res4), 1);
    chk("frz_e5_bias", int'(dut4.w_bias), 1);
    for (int i = 0; i < 10; i++) step(14'h0001, 1'b0);
    chk("frz_w0", int'(dut4.w_w[0]), 1);
    chk("frz_w1", int'(dut4.w_w[1]), -1);
    chk("frz_w2", int'(dut4.w_w[2]), 1);
    chk("frz_bias", int'(dut4.w_bias), 1);
    chk("frz_result", int'(res4), 1);
    chk("nofrz_w0", int'(dut0.w_w[0]), -2);
    chk("nofrz_bias", int'(dut0.w_bias), -2);
    chk("nofrz_result", int'(res0), 0);

    // Learnability of y = x[3] | x[7]
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lab = 1'b0;
    for (int i = 0; i < 2001; i++) begin
      xs = N_IN'($urandom());
      step(xs, lab);
      lab = xs[3] | xs[7];
    end
    n_ok = 0;
    for (int i = 0; i < 500; i++) begin
      xs = N_IN'($urandom());
      step(xs, lab);
      lab = xs[3] | xs[7];
      if (resl == lab) n_ok++;
    end
    $display("info learn: %0d of 500 correct", n_ok);
    chk("learn_acc_ge_99pct", int'(n_ok >= 495), 1);
    chk("learn_cnt_sat", int'(dutl.r_upd_cnt), 2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
